// File: rtl/serial_word_tx.sv
// ============================================================================
// Module   : serial_word_tx
// Purpose  : Shifts a loaded WIDTH-bit word out MSB-first, reps+1 frames,
//            then pulses done. Define SERIAL_WORD_TX_PARITY_EN for a trailing
//            even-parity bit on every frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_word_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             setar_palavra,
  input  logic [WIDTH-1:0] palavra,
  input  logic [3:0]       reps,
  input  logic             start,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] word_q;
  logic [3:0]       reps_q;
  logic [CW-1:0]    pos_q;
  logic [3:0]       frame_q;
  logic             bit_out_q;
  logic             bit_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             w_bit;
  logic             w_last;

  // pos_q counts frame position upward; position 0 carries the MSB.
  always_comb begin
    w_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pos_q == CW'(WIDTH - 1 - i)) w_bit = word_q[i];
    end
`ifdef SERIAL_WORD_TX_PARITY_EN
    if (pos_q == CW'(WIDTH)) w_bit = ^word_q;
`endif
    w_last = (pos_q == CW'(FRAME - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      reps_q      <= '0;
      pos_q       <= '0;
      frame_q     <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (setar_palavra) begin
            word_q  <= palavra;
            reps_q  <= reps;
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (setar_palavra) begin
            word_q <= palavra;
            reps_q <= reps;
          end else if (start) begin
            pos_q   <= '0;
            frame_q <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bit_out_q   <= w_bit;
          bit_valid_q <= 1'b1;
          busy_q      <= 1'b1;
          if (abort) begin
            pos_q   <= '0;
            frame_q <= '0;
            state_q <= S_ARMED;
          end else if (w_last) begin
            pos_q <= '0;
            if (frame_q < reps_q) frame_q <= frame_q + 4'd1;
            else                  state_q <= S_DONE;
          end else begin
            pos_q <= pos_q + 1'b1;
          end
        end
        S_DONE: begin
          // Hold DONE through the pulse cycle so a start there is ignored.
          if (!done_q) done_q  <= 1'b1;
          else         state_q <= S_ARMED;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_tx.sv
// ============================================================================
// Module   : tb_serial_word_tx
// Purpose  : Directed vector table plus multi-cycle sequences for serial_word_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_word_tx;
  localparam int W = 8;
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         setar_palavra = 1'b0;
  logic [W-1:0] palavra = '0;
  logic [3:0]   reps = '0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         bit_out;
  logic         bit_valid;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  serial_word_tx #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .setar_palavra (setar_palavra),
    .palavra       (palavra),
    .reps          (reps),
    .start         (start),
    .abort         (abort),
    .bit_out       (bit_out),
    .bit_valid     (bit_valid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] p;
    logic [3:0]   r;
    logic         st;
    logic         ab;
    logic [3:0]   exp;   // {bit_out, bit_valid, busy, done}
  } vec_t;

  vec_t tbl[$];

  task automatic step(input logic s, input logic [W-1:0] p, input logic [3:0] r,
                      input logic st, input logic ab);
    setar_palavra = s;
    palavra       = p;
    reps          = r;
    start         = st;
    abort         = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {bit_out, bit_valid, busy, done};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (bit_out,bit_valid,busy,done)", name, act, exp);
    end
  endtask

  // Call right after the step that sampled start; checks every frame bit,
  // the done pulse and the return to quiet outputs.
  task automatic expect_tx(input logic [W-1:0] w, input int nframes,
                           input logic noisy, input string name);
    logic b;
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < F; i++) begin
        if (noisy) step(1'b1, '0, 4'hF, 1'b1, 1'b0);
        else       step(1'b0, '0, 4'h0, 1'b0, 1'b0);
        b = (i < W) ? w[W-1-i] : ^w;
        chk($sformatf("%s f%0d b%0d", name, f, i), {b, 3'b110});
      end
    end
    if (noisy) step(1'b1, '0, 4'hF, 1'b1, 1'b0);
    else       step(1'b0, '0, 4'h0, 1'b0, 1'b0);
    chk($sformatf("%s done", name), 4'b0001);
    if (noisy) step(1'b1, '0, 4'hF, 1'b1, 1'b0);
    else       step(1'b0, '0, 4'h0, 1'b0, 1'b0);
    chk($sformatf("%s post", name), 4'b0000);
  endtask

  initial begin
    // Start/abort before any load, same-cycle load+start, then 8'hA5 x1.
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 4'b0000});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1'b1, 8'hA5, 4'd0, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b1110});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b0110});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b1110});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b0110});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b0110});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b1110});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b0110});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b1110});
`ifdef SERIAL_WORD_TX_PARITY_EN
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b0110});
`endif
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b0001});
    tbl.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 4'b0000});

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'b0000);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].p, tbl[i].r, tbl[i].st, tbl[i].ab);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // 8'h3C, three frames, then a restart without reloading.
    step(1'b1, 8'h3C, 4'd2, 1'b0, 1'b0);
    chk("load3C", 4'b0000);
    step(1'b0, '0, 4'd0, 1'b1, 1'b0);
    chk("start3C", 4'b0000);
    expect_tx(8'h3C, 3, 1'b0, "tx3C");
    step(1'b0, '0, 4'd0, 1'b1, 1'b0);
    chk("restart3C", 4'b0000);
    expect_tx(8'h3C, 3, 1'b0, "re3C");

    // Abort sampled on the edge that emits the 4th bit of 8'hFF.
    step(1'b1, 8'hFF, 4'd0, 1'b0, 1'b0);
    step(1'b0, '0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 4'd0, 1'b0, 1'b0);
      chk($sformatf("ff b%0d", i), 4'b1110);
    end
    step(1'b0, '0, 4'd0, 1'b0, 1'b1);
    chk("ff b3 abort", 4'b1110);
    step(1'b0, '0, 4'd0, 1'b0, 1'b0);
    chk("ff after abort", 4'b0000);
    step(1'b0, '0, 4'd0, 1'b0, 1'b0);
    chk("ff no done", 4'b0000);
    step(1'b0, '0, 4'd0, 1'b1, 1'b0);
    chk("ff restart", 4'b0000);
    expect_tx(8'hFF, 1, 1'b0, "txFF");

    // Load/start attempts of 8'h00 while 8'hF0 is shifting are ignored.
    step(1'b1, 8'hF0, 4'd0, 1'b0, 1'b0);
    step(1'b0, '0, 4'd0, 1'b1, 1'b0);
    expect_tx(8'hF0, 1, 1'b1, "txF0 noisy");
    step(1'b0, '0, 4'd0, 1'b1, 1'b0);
    chk("F0 restart", 4'b0000);
    expect_tx(8'hF0, 1, 1'b0, "txF0 kept");

`ifdef SERIAL_WORD_TX_PARITY_EN
    step(1'b1, 8'h07, 4'd1, 1'b0, 1'b0);
    step(1'b0, '0, 4'd0, 1'b1, 1'b0);
    expect_tx(8'h07, 2, 1'b0, "tx07 par");
`endif

    // Asynchronous reset in mid-frame.
    step(1'b1, 8'h81, 4'd3, 1'b0, 1'b0);
    step(1'b0, '0, 4'd0, 1'b1, 1'b0);
    step(1'b0, '0, 4'd0, 1'b0, 1'b0);
    chk("81 b0", 4'b1110);
    step(1'b0, '0, 4'd0, 1'b0, 1'b0);
    chk("81 b1", 4'b0110);
    #2 rst_n = 1'b0;
    #1 chk("async reset", 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, '0, 4'd0, 1'b1, 1'b0);
    chk("idle after rst", 4'b0000);
    step(1'b0, '0, 4'd0, 1'b0, 1'b0);
    chk("no tx after rst", 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
